weight_load_ctrl: RTL and testbench

WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

---
 rtl/weight_load_ctrl_pkg.sv | 20 ++
 rtl/weight_load_ctrl_if.sv | 13 +
 rtl/weight_load_ctrl_skew.sv | 48 ++++
 rtl/weight_load_ctrl.sv | 113 +++++++++++
 tb/tb_weight_load_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/weight_load_ctrl_pkg.sv
// Shared definitions for the layer sequencer and the weight-load controller:
// sequencer mode codes and the weight-load FSM state encoding.
package weight_load_ctrl_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE  = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_LAYER = 3'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wl_state_e;

endpackage

// File: rtl/weight_load_ctrl_if.sv
// Weight-memory read port: strobe + address out, data back one cycle later.
interface weight_load_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int COLS   = 4,
  parameter int DATA_W = 8
);
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [COLS*DATA_W-1:0] mem_rd_data;

  modport master (output mem_rd_en, output mem_addr, input  mem_rd_data);
  modport slave  (input  mem_rd_en, input  mem_addr, output mem_rd_data);
endinterface

// File: rtl/weight_load_ctrl_skew.sv
// weight_skew: lane c of the incoming word is delayed by c cycles; lanes whose
// valid is low are driven to zero.
module weight_skew #(
  parameter int COLS   = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COLS*DATA_W-1:0] in_data,
  input  logic                   in_vld,
  output logic [COLS*DATA_W-1:0] out_data,
  output logic [COLS-1:0]        out_vld
);

  assign out_vld[0]           = in_vld;
  assign out_data[0 +: DATA_W] = in_vld ? in_data[0 +: DATA_W] : '0;

  for (genvar c = 1; c < COLS; c++) begin : g_lane
    logic [DATA_W-1:0] dat_q [c];
    logic [DATA_W-1:0] dat_d [c];
    logic [c-1:0]      vld_q;
    logic [c-1:0]      vld_d;

    always_comb begin
      dat_d[0] = in_data[c*DATA_W +: DATA_W];
      vld_d    = '0;
      vld_d[0] = in_vld;
      for (int k = 1; k < c; k++) begin
        dat_d[k] = dat_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < c; k++) dat_q[k] <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign out_vld[c]                 = vld_q[c-1];
    assign out_data[c*DATA_W +: DATA_W] = vld_q[c-1] ? dat_q[c-1] : '0;
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight-load controller: reads ROWS words (last row first) and feeds them
// skewed to the array. Optional macro WEIGHT_LOAD_MODE_CHECK_EN gates starts on mode==LOAD.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_weights,
  input  logic [MODE_W-1:0]      mode,
  input  logic [ADDR_W-1:0]      base_addr,
  weight_load_ctrl_if.master     mem,
  output logic [COLS*DATA_W-1:0] w_out,
  output logic [COLS-1:0]        w_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   start_overrun
);

  localparam int CNT_W = $clog2(ROWS + 1);

  wl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              ovr_q, ovr_d;
  logic              mode_ok;
  logic              vld_last;

`ifdef WEIGHT_LOAD_MODE_CHECK_EN
  assign mode_ok = (mode == MODE_LOAD);
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign mode_ok     = 1'b1;
`endif

  assign vld_last = w_valid[COLS-1];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    row_cnt_d = row_cnt_q;
    vcnt_d    = vcnt_q;
    rd_vld_d  = (state_q == ST_READ);
    // Any start outside IDLE (including the DONE cycle) or a rejected mode is an overrun.
    ovr_d     = start_weights && ((state_q != ST_IDLE) || !mode_ok);
    if (vld_last) vcnt_d = vcnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_weights && mode_ok) begin
          state_d   = ST_READ;
          addr_d    = base_addr + ADDR_W'(ROWS - 1);
          row_cnt_d = '0;
          vcnt_d    = '0;
        end
      end
      ST_READ: begin
        addr_d    = addr_q - ADDR_W'(1);
        row_cnt_d = row_cnt_q + CNT_W'(1);
        if (row_cnt_q == CNT_W'(ROWS - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vld_last && (vcnt_q == CNT_W'(ROWS - 1))) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      row_cnt_q <= '0;
      vcnt_q    <= '0;
      rd_vld_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      row_cnt_q <= row_cnt_d;
      vcnt_q    <= vcnt_d;
      rd_vld_q  <= rd_vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mem.mem_rd_en  = (state_q == ST_READ);
  assign mem.mem_addr   = (state_q == ST_READ) ? addr_q : '0;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign start_overrun  = ovr_q;

  weight_skew #(
    .COLS   (COLS),
    .DATA_W (DATA_W)
  ) u_skew (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (mem.mem_rd_data),
    .in_vld   (rd_vld_q),
    .out_data (w_out),
    .out_vld  (w_valid)
  );

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl (ROWS=COLS=4, DATA_W=ADDR_W=8): cycle tables
// plus hand sequences for mid-load reset and mode handling.
module tb_weight_load_ctrl;
  import weight_load_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_weights;
  logic [2:0]  mode;
  logic [7:0]  base_addr;
  logic [31:0] w_out;
  logic [3:0]  w_valid;
  logic        busy, done, start_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  weight_load_ctrl_if #(.ADDR_W(8), .COLS(4), .DATA_W(8)) mem_if ();

  weight_load_ctrl #(.ROWS(4), .COLS(4), .DATA_W(8), .ADDR_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_weights (start_weights),
    .mode          (mode),
    .base_addr     (base_addr),
    .mem           (mem_if),
    .w_out         (w_out),
    .w_valid       (w_valid),
    .busy          (busy),
    .done          (done),
    .start_overrun (start_overrun)
  );

  always #5 clk = ~clk;

  // Word at address a holds lane c = {a[3:0], c[3:0]}.
  logic [31:0] mem [256];
  always @(posedge clk) if (mem_if.mem_rd_en) mem_if.mem_rd_data <= mem[mem_if.mem_addr];

  typedef struct packed {
    logic        start;
    logic [2:0]  mode;
    logic [7:0]  base;
    logic        rd_en;
    logic [7:0]  addr;
    logic [3:0]  wv;
    logic [31:0] w;
    logic        busy;
    logic        done;
    logic        ovr;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(logic st, logic [7:0] b, logic re, logic [7:0] ad,
                              logic [3:0] wv, logic [31:0] w, logic bz, logic dn, logic ov);
    vec_t v;
    v.start = st; v.mode = 3'd1; v.base = b; v.rd_en = re; v.addr = ad;
    v.wv = wv; v.w = w; v.busy = bz; v.done = dn; v.ovr = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic re, input logic [7:0] ad,
                           input logic [3:0] wv, input logic [31:0] w,
                           input logic bz, input logic dn, input logic ov);
    check({tag, ".rd_en"},   32'(mem_if.mem_rd_en), 32'(re));
    check({tag, ".addr"},    32'(mem_if.mem_addr),  32'(ad));
    check({tag, ".w_valid"}, 32'(w_valid),          32'(wv));
    check({tag, ".w_out"},   w_out,                 w);
    check({tag, ".busy"},    32'(busy),             32'(bz));
    check({tag, ".done"},    32'(done),             32'(dn));
    check({tag, ".ovr"},     32'(start_overrun),    32'(ov));
  endtask

  // Called at a falling edge: check this cycle's outputs, drive this cycle's inputs.
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check_all($sformatf("vec%0d", i), vecs[i].rd_en, vecs[i].addr, vecs[i].wv,
                vecs[i].w, vecs[i].busy, vecs[i].done, vecs[i].ovr);
      start_weights = vecs[i].start;
      mode          = vecs[i].mode;
      base_addr     = vecs[i].base;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int seen_busy;
    int seen_done;

    rst_n = 1'b0; start_weights = 1'b0; mode = 3'd1; base_addr = 8'h00;
    for (int a = 0; a < 256; a++)
      for (int c = 0; c < 4; c++) mem[a][c*8 +: 8] = 8'((a % 16) * 16 + c);

    // base 0x10, extra starts at cycles 4 and 9 are overruns
    vecs[0]  = mk(1, 8'h10, 0, 8'h00, 4'h0, 32'h00000000, 0, 0, 0);
    vecs[1]  = mk(0, 8'h00, 1, 8'h13, 4'h0, 32'h00000000, 1, 0, 0);
    vecs[2]  = mk(0, 8'h00, 1, 8'h12, 4'h1, 32'h00000030, 1, 0, 0);
    vecs[3]  = mk(0, 8'h00, 1, 8'h11, 4'h3, 32'h00003120, 1, 0, 0);
    vecs[4]  = mk(1, 8'h55, 1, 8'h10, 4'h7, 32'h00322110, 1, 0, 0);
    vecs[5]  = mk(0, 8'h00, 0, 8'h00, 4'hF, 32'h33221100, 1, 0, 1);
    vecs[6]  = mk(0, 8'h00, 0, 8'h00, 4'hE, 32'h23120100, 1, 0, 0);
    vecs[7]  = mk(0, 8'h00, 0, 8'h00, 4'hC, 32'h13020000, 1, 0, 0);
    vecs[8]  = mk(0, 8'h00, 0, 8'h00, 4'h8, 32'h03000000, 1, 0, 0);
    vecs[9]  = mk(1, 8'h77, 0, 8'h00, 4'h0, 32'h00000000, 1, 1, 0);
    vecs[10] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h00000000, 0, 0, 1);
    vecs[11] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h00000000, 0, 0, 0);
    // base 0xFE: address wraps
    vecs[12] = mk(1, 8'hFE, 0, 8'h00, 4'h0, 32'h00000000, 0, 0, 0);
    vecs[13] = mk(0, 8'h00, 1, 8'h01, 4'h0, 32'h00000000, 1, 0, 0);
    vecs[14] = mk(0, 8'h00, 1, 8'h00, 4'h1, 32'h00000010, 1, 0, 0);
    vecs[15] = mk(0, 8'h00, 1, 8'hFF, 4'h3, 32'h00001100, 1, 0, 0);
    vecs[16] = mk(0, 8'h00, 1, 8'hFE, 4'h7, 32'h001201F0, 1, 0, 0);
    vecs[17] = mk(0, 8'h00, 0, 8'h00, 4'hF, 32'h1302F1E0, 1, 0, 0);
    vecs[18] = mk(0, 8'h00, 0, 8'h00, 4'hE, 32'h03F2E100, 1, 0, 0);
    vecs[19] = mk(0, 8'h00, 0, 8'h00, 4'hC, 32'hF3E20000, 1, 0, 0);
    vecs[20] = mk(0, 8'h00, 0, 8'h00, 4'h8, 32'hE3000000, 1, 0, 0);
    vecs[21] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h00000000, 1, 1, 0);
    vecs[22] = mk(0, 8'h00, 0, 8'h00, 4'h0, 32'h00000000, 0, 0, 0);

    repeat (2) @(negedge clk);
    check_all("reset", 0, 8'h00, 4'h0, 32'h0, 0, 0, 0);

    // First start lands on the first rising edge after release.
    rst_n = 1'b1;
    run_range(0, 11);
    run_range(12, 22);

    // Reset in the middle of a load.
    start_weights = 1'b1; base_addr = 8'h10; mode = 3'd1;
    @(negedge clk);
    start_weights = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst.pre_rd_en", 32'(mem_if.mem_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all("midrst", 0, 8'h00, 4'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_busy = 0; seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) seen_busy++;
      if (done) seen_done++;
    end
    check("midrst.busy_after", 32'(seen_busy), 32'd0);
    check("midrst.done_after", 32'(seen_done), 32'd0);
    run_range(0, 11);

`ifdef WEIGHT_LOAD_MODE_CHECK_EN
    start_weights = 1'b1; mode = 3'd2; base_addr = 8'h20;
    @(negedge clk);
    start_weights = 1'b0; mode = 3'd1;
    check("modechk.rd_en", 32'(mem_if.mem_rd_en), 32'd0);
    check("modechk.busy",  32'(busy),             32'd0);
    check("modechk.ovr",   32'(start_overrun),    32'd1);
    @(negedge clk);
    check("modechk.ovr_end", 32'(start_overrun), 32'd0);
    run_range(0, 11);
`else
    start_weights = 1'b1; mode = 3'd2; base_addr = 8'h20;
    @(negedge clk);
    start_weights = 1'b0; mode = 3'd1;
    check("modeany.rd_en", 32'(mem_if.mem_rd_en), 32'd1);
    check("modeany.addr",  32'(mem_if.mem_addr),  32'h23);
    check("modeany.busy",  32'(busy),             32'd1);
    check("modeany.ovr",   32'(start_overrun),    32'd0);
    cyc = 1;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("modeany.done_cycle", 32'(cyc), 32'd9);
    @(negedge clk);
    check("modeany.idle", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
